// File: rtl/flasher_pkg.sv
// Shared types and constants for the flasher run scheduler.
package flasher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // LED bus patterns the scheduler reacts to.
    localparam logic [15:0] LED_OFF  = 16'h0000;
    localparam logic [15:0] LED_B5   = 16'h003F;
    localparam logic [15:0] LED_B10  = 16'h07FF;
    localparam logic [15:0] LED_FULL = 16'hFFFF;

    // Width of a requester index; never zero so a single requester still has a port.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold every value 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/flasher_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first set request scanning upward from ptr.
module rr_arbiter
    import flasher_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   id,
    output logic            valid
);

    logic [IW:0]     cand_sum [NREQ];
    logic [IW-1:0]   cand_idx [NREQ];
    logic [NREQ-1:0] cand_req;

    // Candidate gi is the requester gi positions after the pointer, wrapped modulo NREQ.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        assign cand_sum[gi] = {1'b0, ptr} + (IW+1)'(gi);
        assign cand_idx[gi] = (cand_sum[gi] >= (IW+1)'(NREQ))
                            ? IW'(cand_sum[gi] - (IW+1)'(NREQ))
                            : cand_sum[gi][IW-1:0];
        assign cand_req[gi] = req[cand_idx[gi]];
    end

    // Lowest rotation offset with a pending request wins.
    always_comb begin
        gnt   = '0;
        id    = '0;
        valid = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (cand_req[i]) begin
                valid = 1'b1;
                id    = cand_idx[i];
            end
        end
        if (valid) begin
            gnt[id] = 1'b1;
        end
    end

endmodule

// File: rtl/flasher_sched.sv
// Run scheduler sharing one flasher between NREQ requesters (round-robin),
// with start flick, optional kickback flicks, completion detection and watchdog.
module flasher_sched
    import flasher_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int TIMEOUT  = 255,
    parameter int GAP      = 2,
    parameter int MAX_KICK = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           req_kick,
    input  logic [15:0]               led_in,
    output logic                      flick,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           done,
    output logic                      timeout_err,
    output logic                      busy,
    output logic [id_width(NREQ)-1:0] grant_id
);

    localparam int IW = id_width(NREQ);
    localparam int WW = cnt_width(TIMEOUT);
    localparam int KW = cnt_width(MAX_KICK);
    localparam int GW = cnt_width(GAP);
    // Watchdog value seen in the last START/RUN cycle allowed before abort.
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    state_t          state_reg, state_next;
    logic [IW-1:0]   ptr_reg, ptr_next;
    logic [IW-1:0]   grant_id_reg, grant_id_next;
    logic            kick_reg, kick_next;
    logic [KW-1:0]   kick_cnt_reg, kick_cnt_next;
    logic [WW-1:0]   wd_reg, wd_next;
    logic            seen_full_reg, seen_full_next;
    logic [GW-1:0]   gap_reg, gap_next;
    logic [NREQ-1:0] gnt_reg, gnt_next;
    logic [NREQ-1:0] done_reg, done_next;
    logic            tmo_reg, tmo_next;
    logic            flick_comb;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_id;
    logic            arb_valid;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_reg),
        .gnt   (arb_gnt),
        .id    (arb_id),
        .valid (arb_valid)
    );

    // State and bookkeeping registers; reset abandons any run silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= '0;
            grant_id_reg  <= '0;
            kick_reg      <= 1'b0;
            kick_cnt_reg  <= '0;
            wd_reg        <= '0;
            seen_full_reg <= 1'b0;
            gap_reg       <= '0;
            gnt_reg       <= '0;
            done_reg      <= '0;
            tmo_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            grant_id_reg  <= grant_id_next;
            kick_reg      <= kick_next;
            kick_cnt_reg  <= kick_cnt_next;
            wd_reg        <= wd_next;
            seen_full_reg <= seen_full_next;
            gap_reg       <= gap_next;
            gnt_reg       <= gnt_next;
            done_reg      <= done_next;
            tmo_reg       <= tmo_next;
        end
    end

    // Next-state logic; pulses are registered so they appear with the new state.
    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        grant_id_next  = grant_id_reg;
        kick_next      = kick_reg;
        kick_cnt_next  = kick_cnt_reg;
        wd_next        = wd_reg;
        seen_full_next = seen_full_reg;
        gap_next       = gap_reg;
        gnt_next       = '0;
        done_next      = '0;
        tmo_next       = 1'b0;
        flick_comb     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (arb_valid) begin
                    gnt_next       = arb_gnt;
                    grant_id_next  = arb_id;
                    kick_next      = req_kick[arb_id];
                    ptr_next       = (arb_id == IW'(NREQ - 1)) ? '0 : arb_id + IW'(1);
                    kick_cnt_next  = '0;
                    wd_next        = '0;
                    seen_full_next = 1'b0;
                    state_next     = ST_START;
                end
            end
            ST_START: begin
                if (wd_reg >= WD_LAST) begin
                    tmo_next   = 1'b1;
                    gap_next   = '0;
                    state_next = ST_GAP;
                end else begin
                    flick_comb = 1'b1;
                    wd_next    = wd_reg + WW'(1);
                    if (led_in != LED_OFF) begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // Completion beats the watchdog when both land in the same cycle.
                if (seen_full_reg && led_in == LED_OFF) begin
                    done_next[grant_id_reg] = 1'b1;
                    gap_next   = '0;
                    state_next = ST_GAP;
                end else if (wd_reg >= WD_LAST) begin
                    tmo_next   = 1'b1;
                    gap_next   = '0;
                    state_next = ST_GAP;
                end else begin
                    wd_next    = wd_reg + WW'(1);
                    flick_comb = kick_reg && (kick_cnt_reg < KW'(MAX_KICK)) &&
                                 (led_in == LED_B5 || led_in == LED_B10);
                    if (flick_comb) begin
                        kick_cnt_next = kick_cnt_reg + KW'(1);
                    end
                    if (led_in == LED_FULL) begin
                        seen_full_next = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_reg >= GW'(GAP) && led_in == LED_OFF) begin
                    state_next = ST_IDLE;
                end else if (gap_reg < GW'(GAP)) begin
                    gap_next = gap_reg + GW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign flick       = flick_comb;
    assign gnt         = gnt_reg;
    assign done        = done_reg;
    assign timeout_err = tmo_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign grant_id    = grant_id_reg;

endmodule

// File: tb/tb_flasher_sched.sv
// Bench for flasher_sched: randomized runs against a timeline model derived from the LED sequence.
module tb_flasher_sched;

    localparam int NREQ     = 3;
    localparam int TIMEOUT  = 255;
    localparam int GAP      = 2;
    localparam int MAX_KICK = 1;
    localparam int IW       = 2;
    localparam int SEQ_MAX  = 400;
    localparam logic [15:0] B5   = 16'h003F;
    localparam logic [15:0] B10  = 16'h07FF;
    localparam logic [15:0] FULL = 16'hFFFF;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req, req_kick, gnt, done;
    logic [15:0]     led_in;
    logic            flick, timeout_err, busy;
    logic [IW-1:0]   grant_id;

    int tests_run    = 0;
    int tests_failed = 0;
    int next_start   = 0;
    int run_no       = 0;
    int cur_k        = 0;

    logic [15:0] seq     [SEQ_MAX];
    bit          is_kick [SEQ_MAX];

    always #5 clk = ~clk;

    flasher_sched #(
        .NREQ     (NREQ),
        .TIMEOUT  (TIMEOUT),
        .GAP      (GAP),
        .MAX_KICK (MAX_KICK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_kick    (req_kick),
        .led_in      (led_in),
        .flick       (flick),
        .gnt         (gnt),
        .done        (done),
        .timeout_err (timeout_err),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s run %0d k %0d: observed %0h expected %0h", tag, run_no, cur_k, got, exp);
        end
    endtask

    // First requester holding req, scanning upward from start with wrap.
    function automatic int pick(input logic [NREQ-1:0] r, input int start);
        for (int o = 0; o < NREQ; o++) begin
            if (r[(start + o) % NREQ]) return (start + o) % NREQ;
        end
        return 0;
    endfunction

    function automatic int find_led(input int from, input logic [15:0] v);
        for (int k = from; k < SEQ_MAX; k++) begin
            if (seq[k] == v) return k;
        end
        return SEQ_MAX;
    endfunction

    function automatic int find_nonzero(input int from);
        for (int k = from; k < SEQ_MAX; k++) begin
            if (seq[k] != 16'h0000) return k;
        end
        return SEQ_MAX;
    endfunction

    // kind 0: full up/down sweep; kind 1: LED stuck at 0x0001; kind 2: LEDs never light.
    task automatic build_seq(input int kind, input bit early_off, input int tail_hold);
        int          p;
        logic [15:0] v;
        for (int k = 0; k < SEQ_MAX; k++) seq[k] = 16'h0000;
        p = int'($urandom_range(0, 3));
        if (kind == 1) begin
            repeat (TIMEOUT + tail_hold) begin seq[p] = 16'h0001; p++; end
        end else if (kind == 0) begin
            if (early_off) begin
                v = 16'h0000;
                for (int b = 0; b < 6; b++) begin v = {v[14:0], 1'b1}; seq[p] = v; p++; end
                repeat ($urandom_range(1, 2)) begin seq[p] = 16'h0000; p++; end
            end
            v = 16'h0000;
            for (int b = 0; b < 16; b++) begin
                v = {v[14:0], 1'b1};
                repeat ($urandom_range(1, 2)) begin seq[p] = v; p++; end
            end
            for (int b = 0; b < 15; b++) begin
                v = {1'b0, v[15:1]};
                repeat ($urandom_range(1, 2)) begin seq[p] = v; p++; end
            end
            p++;
            repeat (tail_hold) begin seq[p] = 16'h0001; p++; end
        end
    endtask

    // One scheduled run: predict its timeline from the LED sequence, then check every cycle.
    task automatic do_run(input logic [NREQ-1:0] r, input logic [NREQ-1:0] kv,
                          input int kind, input bit early_off, input int tail_hold);
        int              id, first_nz, full_k, done_k, end_k, idle_k, kicks, j;
        bit              tmo, exp_flick, kick_on;
        logic [NREQ-1:0] oh;
        run_no++;
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            #1;
            check("idle_busy", busy, 0);
            check("idle_gnt", gnt, 0);
        end
        id = pick(r, next_start);
        next_start = (id + 1) % NREQ;
        kick_on = kv[id];
        oh = '0;
        oh[id] = 1'b1;
        build_seq(kind, early_off, tail_hold);

        // Timeline: start phase ends at the first lit LED; done needs all-on then all-off.
        first_nz = find_nonzero(0);
        full_k   = (first_nz < SEQ_MAX) ? find_led(first_nz + 1, FULL) : SEQ_MAX;
        done_k   = (full_k < SEQ_MAX) ? find_led(full_k + 1, 16'h0000) : SEQ_MAX;
        tmo      = (done_k > TIMEOUT - 1);
        end_k    = tmo ? TIMEOUT - 1 : done_k;
        kicks    = 0;
        for (int k = 0; k < SEQ_MAX; k++) begin
            is_kick[k] = 1'b0;
            if (kick_on && k > first_nz && k < end_k && kicks < MAX_KICK &&
                (seq[k] == B5 || seq[k] == B10)) begin
                is_kick[k] = 1'b1;
                kicks++;
            end
        end
        j = end_k + 1 + GAP;
        while (j < SEQ_MAX - 1 && seq[j] != 16'h0000) j++;
        idle_k = j + 1;
        $display("[TB] run %0d: req=%b kick=%b id=%0d kind=%0d end=%0d %s kicks=%0d idle=%0d",
                 run_no, r, kv, id, kind, end_k, tmo ? "timeout" : "done", kicks, idle_k);

        req      = r;
        req_kick = kv;
        @(posedge clk);
        for (int k = 0; k <= idle_k; k++) begin
            @(negedge clk);
            cur_k  = k;
            led_in = seq[k];
            if (k > end_k) begin
                req      = '0;
                req_kick = '0;
            end else if (k > 0) begin
                req      = NREQ'($urandom);
                req_kick = NREQ'($urandom);
            end
            #1;
            exp_flick = (k <= end_k) && (k <= first_nz || is_kick[k]) && !(tmo && k == end_k);
            check("gnt", gnt, (k == 0) ? oh : '0);
            check("done", done, (k == end_k + 1 && !tmo) ? oh : '0);
            check("timeout_err", timeout_err, (k == end_k + 1 && tmo) ? 1 : 0);
            check("flick", flick, exp_flick);
            check("busy", busy, (k < idle_k) ? 1 : 0);
            check("grant_id", grant_id, id);
        end
    endtask

    // Reset in the middle of a run: everything clears and round-robin restarts at 0.
    task automatic do_reset_mid_run(input logic [NREQ-1:0] r);
        int              id;
        logic [NREQ-1:0] oh;
        run_no++;
        id = pick(r, next_start);
        oh = '0;
        oh[id] = 1'b1;
        $display("[TB] run %0d: reset mid-run req=%b id=%0d", run_no, r, id);
        req      = r;
        req_kick = '0;
        @(posedge clk);
        @(negedge clk);
        cur_k  = 0;
        led_in = 16'h0001;
        #1;
        check("rst_run_gnt", gnt, oh);
        repeat (3) begin
            @(negedge clk);
            led_in = 16'h00FF;
        end
        #1;
        check("rst_run_busy", busy, 1);
        check("rst_run_flick", flick, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        req    = '0;
        led_in = 16'h0000;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_tmo", timeout_err, 0);
        check("rst_flick", flick, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        next_start = 0;
    endtask

    initial begin
        logic [NREQ-1:0] r, kv;
        int              kind;
        rst      = 1'b1;
        req      = '0;
        req_kick = '0;
        led_in   = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_gnt", gnt, 0);
        check("reset_done", done, 0);
        check("reset_tmo", timeout_err, 0);
        check("reset_flick", flick, 0);
        check("reset_busy", busy, 0);
        check("reset_grant_id", grant_id, 0);

        do_run(3'b001, 3'b000, 0, 1'b0, 0);     // single plain run
        do_run(3'b011, 3'b000, 0, 1'b0, 0);     // round-robin with two holders
        do_run(3'b011, 3'b000, 0, 1'b0, 0);
        do_run(3'b011, 3'b000, 0, 1'b0, 0);
        do_run(3'b001, 3'b001, 0, 1'b0, 0);     // kick mode
        do_run(3'b010, 3'b000, 1, 1'b0, 6);     // stuck LED -> watchdog, GAP held by LED
        do_run(3'b100, 3'b100, 2, 1'b0, 0);     // never lights -> watchdog from START
        do_run(3'b001, 3'b001, 0, 1'b1, 3);     // early all-off must not complete
        do_reset_mid_run(3'b110);
        do_run(3'b111, 3'b000, 0, 1'b0, 0);     // pointer restarts at 0

        for (int n = 0; n < 24; n++) begin
            do r = NREQ'($urandom); while (r == '0);
            kv   = NREQ'($urandom);
            kind = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            do_run(r, kv, kind, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
